// File: rtl/exs_muldiv_pkg.sv
// Shared encodings for the multi-cycle multiply/divide execute unit.
package exs_muldiv_pkg;

  localparam int unsigned REGD_W = 5;
  localparam int unsigned OP_W   = 3;

  // funct3 encodings of the M-extension ops
  typedef enum logic [OP_W-1:0] {
    MDOP_MUL    = 3'd0,
    MDOP_MULH   = 3'd1,
    MDOP_MULHSU = 3'd2,
    MDOP_MULHU  = 3'd3,
    MDOP_DIV    = 3'd4,
    MDOP_DIVU   = 3'd5,
    MDOP_REM    = 3'd6,
    MDOP_REMU   = 3'd7
  } mdop_e;

  typedef enum logic [1:0] {
    MDST_IDLE = 2'd0,
    MDST_MUL  = 2'd1,
    MDST_DIV  = 2'd2,
    MDST_DONE = 2'd3
  } mdst_e;

  // Ops 4..7 are divides; bit 1 within the divide group selects the remainder
  function automatic logic op_is_div(input logic [OP_W-1:0] op);
    return op[2];
  endfunction

  function automatic logic op_is_rem(input logic [OP_W-1:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/exs_muldiv_step.sv
// One iteration of the unsigned datapath: shift-add multiply or restoring
// divide, retiring C_BITS_PER_CYCLE bits. The accumulator holds
// {high, low} = {partial product, multiplier} or {remainder, dividend/quotient}.
module exs_muldiv_step #(
  parameter int unsigned C_XLEN           = 32,
  parameter int unsigned C_BITS_PER_CYCLE = 1
) (
  input  logic                  is_div_i,
  input  logic [C_XLEN-1:0]     opnd_i,
  input  logic [2*C_XLEN-1:0]   acc_i,
  output logic [2*C_XLEN-1:0]   acc_o
);

  logic [2*C_XLEN:0] mul_t;
  logic [C_XLEN:0]   rem_t;
  logic [C_XLEN-1:0] quo_t;

  // Unrolled multi-bit step; the extra top bit carries the add/shift overflow
  always_comb begin
    mul_t = {1'b0, acc_i};
    rem_t = {1'b0, acc_i[2*C_XLEN-1:C_XLEN]};
    quo_t = acc_i[C_XLEN-1:0];
    acc_o = '0;
    if (is_div_i) begin
      for (int unsigned i = 0; i < C_BITS_PER_CYCLE; i++) begin
        rem_t = {rem_t[C_XLEN-1:0], quo_t[C_XLEN-1]};
        quo_t = {quo_t[C_XLEN-2:0], 1'b0};
        if (rem_t >= {1'b0, opnd_i}) begin
          rem_t    = rem_t - {1'b0, opnd_i};
          quo_t[0] = 1'b1;
        end
      end
      acc_o = {rem_t[C_XLEN-1:0], quo_t};
    end else begin
      for (int unsigned i = 0; i < C_BITS_PER_CYCLE; i++) begin
        if (mul_t[0]) begin
          mul_t[2*C_XLEN:C_XLEN] = {1'b0, mul_t[2*C_XLEN-1:C_XLEN]} + {1'b0, opnd_i};
        end
        mul_t = mul_t >> 1;
      end
      acc_o = mul_t[2*C_XLEN-1:0];
    end
  end

endmodule

// File: rtl/exs_muldiv.sv
// Multi-cycle RV32M/RV64M multiply/divide unit beside the execute-stage ALU.
// Works on operand magnitudes and applies the two's-complement sign fix-up
// on the edge that enters DONE.
module exs_muldiv
  import exs_muldiv_pkg::*;
#(
  parameter int unsigned C_XLEN           = 32,
  parameter int unsigned C_BITS_PER_CYCLE = 1,
  parameter bit          C_EARLY_OUT      = 1'b1
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                clk_en_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic [OP_W-1:0]     req_op_i,
  input  logic [C_XLEN-1:0]   req_left_i,
  input  logic [C_XLEN-1:0]   req_right_i,
  input  logic [REGD_W-1:0]   req_regd_addr_i,
  input  logic                kill_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [C_XLEN-1:0]   rsp_data_o,
  output logic [REGD_W-1:0]   rsp_regd_addr_o,
  output logic                busy_o
);

  localparam int unsigned N_ITER = C_XLEN / C_BITS_PER_CYCLE;
  localparam int unsigned CNT_W  = $clog2(N_ITER + 1);

  mdst_e               state_q;
  mdop_e               op_q;
  logic [REGD_W-1:0]   regd_q;
  logic [C_XLEN-1:0]   opnd_q;
  logic [2*C_XLEN-1:0] acc_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                res_neg_q;
  logic                rem_neg_q;
  logic                rsp_valid_q;
  logic [C_XLEN-1:0]   rsp_data_q;
  logic [REGD_W-1:0]   rsp_regd_q;

  logic [2*C_XLEN-1:0] acc_step;

  // Accept-time decode: magnitudes, sign flags, initial datapath load
  logic                l_signed, r_signed, l_neg, r_neg, div_zero, is_div;
  logic [C_XLEN-1:0]   l_mag, r_mag, opnd_d, early_data_d;
  logic [2*C_XLEN-1:0] acc_d;
  logic                res_neg_d, rem_neg_d, early_d;

  // Fix-up of the final iteration result
  logic [2*C_XLEN-1:0] prod_fix;
  logic [C_XLEN-1:0]   quo_mag, rem_mag, result_d;

  exs_muldiv_step #(
    .C_XLEN           (C_XLEN),
    .C_BITS_PER_CYCLE (C_BITS_PER_CYCLE)
  ) u_step (
    .is_div_i (state_q == MDST_DIV),
    .opnd_i   (opnd_q),
    .acc_i    (acc_q),
    .acc_o    (acc_step)
  );

  // Request decode into unsigned magnitudes plus sign flags
  always_comb begin
    l_signed     = (req_op_i == MDOP_MULH) || (req_op_i == MDOP_MULHSU) ||
                   (req_op_i == MDOP_DIV)  || (req_op_i == MDOP_REM);
    r_signed     = (req_op_i == MDOP_MULH) || (req_op_i == MDOP_DIV) ||
                   (req_op_i == MDOP_REM);
    l_neg        = l_signed & req_left_i[C_XLEN-1];
    r_neg        = r_signed & req_right_i[C_XLEN-1];
    l_mag        = l_neg ? (C_XLEN'(0) - req_left_i)  : req_left_i;
    r_mag        = r_neg ? (C_XLEN'(0) - req_right_i) : req_right_i;
    div_zero     = (req_right_i == '0);
    is_div       = op_is_div(req_op_i);
    // A zero divisor yields an all-ones quotient regardless of dividend sign
    res_neg_d    = (l_neg ^ r_neg) & ~(is_div & div_zero);
    rem_neg_d    = l_neg;
    acc_d        = is_div ? {{C_XLEN{1'b0}}, l_mag} : {{C_XLEN{1'b0}}, r_mag};
    opnd_d       = is_div ? r_mag : l_mag;
    early_d      = C_EARLY_OUT && is_div && div_zero;
    early_data_d = op_is_rem(req_op_i) ? req_left_i : '1;
  end

  // Result selection and sign fix-up of the last step's output
  always_comb begin
    prod_fix = res_neg_q ? ((2*C_XLEN)'(0) - acc_step) : acc_step;
    quo_mag  = acc_step[C_XLEN-1:0];
    rem_mag  = acc_step[2*C_XLEN-1:C_XLEN];
    result_d = '0;
    case (op_q)
      MDOP_MUL:                          result_d = prod_fix[C_XLEN-1:0];
      MDOP_MULH, MDOP_MULHSU, MDOP_MULHU: result_d = prod_fix[2*C_XLEN-1:C_XLEN];
      MDOP_DIV, MDOP_DIVU:               result_d = res_neg_q ? (C_XLEN'(0) - quo_mag) : quo_mag;
      default:                           result_d = rem_neg_q ? (C_XLEN'(0) - rem_mag) : rem_mag;
    endcase
  end

  // FSM, iteration counter, operand registers and registered response
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= MDST_IDLE;
      op_q        <= MDOP_MUL;
      regd_q      <= '0;
      opnd_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      res_neg_q   <= 1'b0;
      rem_neg_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_regd_q  <= '0;
    end else if (clk_en_i) begin
      if (kill_i) begin
        state_q     <= MDST_IDLE;
        rsp_valid_q <= 1'b0;
      end else begin
        case (state_q)
          MDST_IDLE: begin
            if (req_valid_i) begin
              op_q      <= mdop_e'(req_op_i);
              regd_q    <= req_regd_addr_i;
              opnd_q    <= opnd_d;
              acc_q     <= acc_d;
              cnt_q     <= CNT_W'(N_ITER);
              res_neg_q <= res_neg_d;
              rem_neg_q <= rem_neg_d;
              if (early_d) begin
                state_q     <= MDST_DONE;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= early_data_d;
                rsp_regd_q  <= req_regd_addr_i;
              end else begin
                state_q <= is_div ? MDST_DIV : MDST_MUL;
              end
            end
          end
          MDST_MUL, MDST_DIV: begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_q     <= MDST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= result_d;
              rsp_regd_q  <= regd_q;
            end
          end
          MDST_DONE: begin
            if (rsp_ready_i) begin
              state_q     <= MDST_IDLE;
              rsp_valid_q <= 1'b0;
            end
          end
          default: state_q <= MDST_IDLE;
        endcase
      end
    end
  end

  // A kill in DONE must not complete a handshake in the same cycle
  assign rsp_valid_o     = rsp_valid_q & ~kill_i;
  assign req_ready_o     = (state_q == MDST_IDLE);
  assign busy_o          = (state_q != MDST_IDLE);
  assign rsp_data_o      = rsp_data_q;
  assign rsp_regd_addr_o = rsp_regd_q;

endmodule

// File: tb/tb_exs_muldiv.sv
// Directed bench: two instances (1 bit/cycle with early-out, 4 bits/cycle
// without) share stimulus; each response is checked against hand values.
module tb_exs_muldiv;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [31:0] req_left, req_right;
  logic [4:0]  req_regd;
  logic        kill;
  logic        rsp_ready;

  logic        ready1, v1, busy1;
  logic [31:0] d1;
  logic [4:0]  a1;
  logic        ready4, v4, busy4;
  logic [31:0] d4;
  logic [4:0]  a4;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  exs_muldiv #(.C_XLEN(32), .C_BITS_PER_CYCLE(1), .C_EARLY_OUT(1'b1)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .clk_en_i(clk_en),
    .req_valid_i(req_valid), .req_ready_o(ready1), .req_op_i(req_op),
    .req_left_i(req_left), .req_right_i(req_right), .req_regd_addr_i(req_regd),
    .kill_i(kill), .rsp_valid_o(v1), .rsp_ready_i(rsp_ready),
    .rsp_data_o(d1), .rsp_regd_addr_o(a1), .busy_o(busy1)
  );

  exs_muldiv #(.C_XLEN(32), .C_BITS_PER_CYCLE(4), .C_EARLY_OUT(1'b0)) u_dut4 (
    .clk_i(clk), .reset_i(rst), .clk_en_i(clk_en),
    .req_valid_i(req_valid), .req_ready_o(ready4), .req_op_i(req_op),
    .req_left_i(req_left), .req_right_i(req_right), .req_regd_addr_i(req_regd),
    .kill_i(kill), .rsp_valid_o(v4), .rsp_ready_i(rsp_ready),
    .rsp_data_o(d4), .rsp_regd_addr_o(a4), .busy_o(busy4)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] l, input logic [31:0] r,
                       input logic [4:0] rd);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_left = l; req_right = r; req_regd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = ~op; req_left = '0; req_right = '0; req_regd = '0;
  endtask

  // Latency counts the acceptance edge as edge 1; gate = enable-low cycles
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] l,
                        input logic [31:0] r, input logic [4:0] rd, input logic [31:0] exp,
                        input int lat1_exp, input int hold, input int gate);
    int n, lat1, lat4;
    issue(op, l, r, rd);
    if (gate > 0) begin
      clk_en = 1'b0;
      repeat (gate) @(posedge clk);
      @(negedge clk);
      chk({tag, " gated busy"}, 64'(busy4), 64'(1));
      chk({tag, " gated valid"}, 64'(v4), 64'(0));
      clk_en = 1'b1;
    end else begin
      @(negedge clk);
    end
    n = 1; lat1 = 0; lat4 = 0;
    while ((lat1 == 0 || lat4 == 0) && n < 200) begin
      if (lat1 == 0 && v1) lat1 = n;
      if (lat4 == 0 && v4) lat4 = n;
      if (lat1 == 0 || lat4 == 0) begin
        @(negedge clk);
        n++;
      end
    end
    chk({tag, " lat1"}, 64'(lat1), 64'(lat1_exp));
    chk({tag, " lat4"}, 64'(lat4), 64'(9));
    chk({tag, " data1"}, 64'(d1), 64'(exp));
    chk({tag, " data4"}, 64'(d4), 64'(exp));
    chk({tag, " regd1"}, 64'(a1), 64'(rd));
    chk({tag, " regd4"}, 64'(a4), 64'(rd));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, " hold valid"}, 64'(v1), 64'(1));
      chk({tag, " hold data"}, 64'(d1), 64'(exp));
      chk({tag, " hold ready"}, 64'(ready1), 64'(0));
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, " drop valid1"}, 64'(v1), 64'(0));
    chk({tag, " drop valid4"}, 64'(v4), 64'(0));
    chk({tag, " idle ready1"}, 64'(ready1), 64'(1));
    chk({tag, " idle ready4"}, 64'(ready4), 64'(1));
  endtask

  initial begin
    int seen;
    rst = 1'b1; clk_en = 1'b1; req_valid = 1'b0; req_op = '0; req_left = '0;
    req_right = '0; req_regd = '0; kill = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst valid", 64'(v1), 64'(0));
    chk("rst data", 64'(d1), 64'(0));
    chk("rst regd", 64'(a1), 64'(0));
    chk("rst busy", 64'(busy1), 64'(0));
    chk("rst ready", 64'(ready1), 64'(1));
    rst = 1'b0;

    run_op("mul",      3'd0, 32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 33, 0, 0);
    run_op("mulh",     3'd1, 32'h80000000, 32'h80000000, 5'd6,  32'h40000000, 33, 0, 0);
    run_op("mulhu",    3'd3, 32'h80000000, 32'h80000000, 5'd7,  32'h40000000, 33, 0, 0);
    run_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'h00000002, 5'd8,  32'hFFFFFFFF, 33, 0, 0);
    run_op("mulhu_m1", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd9,  32'hFFFFFFFE, 33, 0, 0);
    run_op("mulh_m1",  3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd10, 32'h00000000, 33, 0, 0);
    run_op("mul_gate", 3'd0, 32'h12345678, 32'd9,        5'd11, 32'hA3D70A38, 33, 0, 5);
    run_op("divu_z",   3'd5, 32'd100,      32'd0,        5'd12, 32'hFFFFFFFF, 1,  0, 0);
    run_op("remu_z",   3'd7, 32'd100,      32'd0,        5'd13, 32'd100,      1,  0, 0);
    run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 33, 0, 0);
    run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 33, 0, 0);
    run_op("rem_n7_2", 3'd6, 32'hFFFFFFF9, 32'd2,        5'd16, 32'hFFFFFFFF, 33, 0, 0);
    run_op("div_n7_2", 3'd4, 32'hFFFFFFF9, 32'd2,        5'd17, 32'hFFFFFFFD, 33, 0, 0);
    run_op("div_7_n2", 3'd4, 32'd7,        32'hFFFFFFFE, 5'd18, 32'hFFFFFFFD, 33, 0, 0);
    run_op("rem_7_n2", 3'd6, 32'd7,        32'hFFFFFFFE, 5'd19, 32'd1,        33, 0, 0);
    run_op("div_n7_z", 3'd4, 32'hFFFFFFF9, 32'd0,        5'd20, 32'hFFFFFFFF, 1,  0, 0);
    run_op("rem_n7_z", 3'd6, 32'hFFFFFFF9, 32'd0,        5'd21, 32'hFFFFFFF9, 1,  0, 0);
    run_op("divu_16",  3'd5, 32'hFFFFFFFF, 32'h10,       5'd22, 32'h0FFFFFFF, 33, 0, 0);
    run_op("remu_16",  3'd7, 32'hFFFFFFFF, 32'h10,       5'd23, 32'h0000000F, 33, 0, 0);
    run_op("mul_hold", 3'd0, 32'd3,        32'd5,        5'd24, 32'd15,       33, 10, 0);

    // kill mid-iteration: back to IDLE, no response ever appears
    issue(3'd5, 32'd1000, 32'd7, 5'd25);
    repeat (4) @(posedge clk);
    @(negedge clk); kill = 1'b1;
    @(posedge clk); #1; kill = 1'b0;
    chk("kill busy1", 64'(busy1), 64'(0));
    chk("kill ready1", 64'(ready1), 64'(1));
    chk("kill busy4", 64'(busy4), 64'(0));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (v1 || v4) seen = 1;
    end
    chk("kill no rsp", 64'(seen), 64'(0));
    run_op("post_kill", 3'd5, 32'd1000, 32'd7, 5'd26, 32'd142, 33, 0, 0);

    // kill during a would-be accept: request not taken
    @(negedge clk); req_valid = 1'b1; req_op = 3'd0; req_left = 32'd2; req_right = 32'd3; kill = 1'b1;
    @(posedge clk); #1; req_valid = 1'b0; kill = 1'b0;
    chk("kill acc busy", 64'(busy1), 64'(0));
    chk("kill acc ready", 64'(ready1), 64'(1));

    // kill in DONE with consumer ready: valid masked, unit returns to IDLE
    issue(3'd0, 32'd4, 32'd4, 5'd27);
    repeat (40) @(negedge clk);
    chk("done pre kill", 64'(v1), 64'(1));
    kill = 1'b1; rsp_ready = 1'b1; #1;
    chk("done kill mask", 64'(v1), 64'(0));
    @(posedge clk); #1; kill = 1'b0; rsp_ready = 1'b0;
    chk("done kill valid", 64'(v1), 64'(0));
    chk("done kill ready", 64'(ready1), 64'(1));

    // reset mid-divide clears outputs immediately
    issue(3'd4, 32'd77, 32'd3, 5'd28);
    repeat (5) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    chk("mid rst valid", 64'(v1), 64'(0));
    chk("mid rst data1", 64'(d1), 64'(0));
    chk("mid rst data4", 64'(d4), 64'(0));
    chk("mid rst regd", 64'(a1), 64'(0));
    chk("mid rst busy", 64'(busy1), 64'(0));
    chk("mid rst ready", 64'(ready1), 64'(1));
    @(negedge clk); rst = 1'b0;
    run_op("post_rst", 3'd4, 32'd77, 32'd3, 5'd29, 32'd25, 33, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
